// File: rtl/test_clock_gen_if.sv
// Control/status bundle for the programmable test-clock source.
// The master drives the requests and configuration. The slave (the generator)
// drives the generated clock and the status signals.
interface test_clock_gen_if #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
);
  logic               start;
  logic               stop;
  logic [CNT_W-1:0]   high_cnt;
  logic [CNT_W-1:0]   low_cnt;
  logic [BURST_W-1:0] burst_len;
  logic               clk_out;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] periods;

  modport master (
    output start, stop, high_cnt, low_cnt, burst_len,
    input  clk_out, busy, done, periods
  );

  modport slave (
    input  start, stop, high_cnt, low_cnt, burst_len,
    output clk_out, busy, done, periods
  );
endinterface

// File: rtl/test_clock_gen.sv
// Programmable test-clock source. It emits whole periods only, with
// programmable high and low widths. It can run a fixed number of periods
// (burst) or run until a stop request arrives. Each period always completes,
// so no runt pulses appear on clk_out. The phase widths are re-sampled only
// at period boundaries.
module test_clock_gen #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  test_clock_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t             state_q,     state_d;
  logic               clk_out_q,   clk_out_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]   ph_cnt_q,    ph_cnt_d;
  logic [CNT_W-1:0]   high_sh_q,   high_sh_d;
  logic [CNT_W-1:0]   low_sh_q,    low_sh_d;
  logic [BURST_W-1:0] burst_sh_q,  burst_sh_d;
  logic [BURST_W-1:0] periods_q,   periods_d;

  logic [CNT_W-1:0]   high_len;
  logic [CNT_W-1:0]   low_len;
  logic [BURST_W:0]   periods_inc;
  logic [BURST_W-1:0] periods_sat;
  logic               finish;

  // Effective phase lengths. A zero width is stretched to one cycle.
  // The period count is widened by one bit so the burst compare never wraps.
  assign high_len    = (high_sh_q == '0) ? CNT_W'(1) : high_sh_q;
  assign low_len     = (low_sh_q  == '0) ? CNT_W'(1) : low_sh_q;
  assign periods_inc = {1'b0, periods_q} + (BURST_W+1)'(1);
  assign periods_sat = (&periods_q) ? periods_q : periods_inc[BURST_W-1:0];
  assign finish      = stop_pend_q |
                       ((burst_sh_q != '0) && (periods_inc == {1'b0, burst_sh_q}));

  // Next-state and output decode for the IDLE/HIGH/LOW phase machine.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path infers a latch.
    state_d     = state_q;
    clk_out_d   = clk_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    stop_pend_d = stop_pend_q;
    ph_cnt_d    = ph_cnt_q;
    high_sh_d   = high_sh_q;
    low_sh_d    = low_sh_q;
    burst_sh_d  = burst_sh_q;
    periods_d   = periods_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          high_sh_d  = bus.high_cnt;
          low_sh_d   = bus.low_cnt;
          burst_sh_d = bus.burst_len;
          state_d    = HIGH;
          clk_out_d  = 1'b1;
          busy_d     = 1'b1;
          periods_d  = '0;
          ph_cnt_d   = CNT_W'(1);
        end
      end
      HIGH: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (ph_cnt_q == high_len) begin
          state_d   = LOW;
          clk_out_d = 1'b0;
          ph_cnt_d  = CNT_W'(1);
        end else begin
          ph_cnt_d  = ph_cnt_q + CNT_W'(1);
        end
      end
      LOW: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (ph_cnt_q == low_len) begin
          // Period boundary.
          periods_d = periods_sat;
          ph_cnt_d  = CNT_W'(1);
          if (finish) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d   = HIGH;
            clk_out_d = 1'b1;
            high_sh_d = bus.high_cnt;
            low_sh_d  = bus.low_cnt;
          end
        end else begin
          ph_cnt_d  = ph_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset that aborts immediately.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!RST_N) begin
      state_q     <= IDLE;
      clk_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      ph_cnt_q    <= '0;
      high_sh_q   <= '0;
      low_sh_q    <= '0;
      burst_sh_q  <= '0;
      periods_q   <= '0;
    end else begin
      state_q     <= state_d;
      clk_out_q   <= clk_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      ph_cnt_q    <= ph_cnt_d;
      high_sh_q   <= high_sh_d;
      low_sh_q    <= low_sh_d;
      burst_sh_q  <= burst_sh_d;
      periods_q   <= periods_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.periods = periods_q;

endmodule

// File: tb/tb_test_clock_gen.sv
// Bench for test_clock_gen. BURST_W is narrowed to 8 so that period-counter
// saturation can be reached in a short run. The stimulus queues the expected
// waveform and final period count of each run. A negedge monitor records
// clk_out while busy and checks the record against the queue on each done
// pulse.
module tb_test_clock_gen;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  test_clock_gen_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  test_clock_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    string name;
    string wave;
    int    periods;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  mon_e;
  int    checks    = 0;
  int    failures  = 0;
  string cap       = "";
  logic  prev_busy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic string rep(input string p, input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, p};
    return s;
  endfunction

  // Index of the first differing character, or -1 if the strings are identical.
  function automatic int first_diff(input string a, input string b);
    int n = (a.len() < b.len()) ? a.len() : b.len();
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    return (a.len() == b.len()) ? -1 : n;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_run(input string name, input string wave, input int periods);
    exp_t e;
    e.name    = name;
    e.wave    = wave;
    e.periods = periods;
    sb_q.push_back(e);
  endtask

  task automatic start_run(input int h, input int l, input int b);
    bus.high_cnt  = CNT_W'(h);
    bus.low_cnt   = CNT_W'(l);
    bus.burst_len = BURST_W'(b);
    bus.start     = 1'b1;
    tick(1);
    bus.start     = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending runs after %0d cycles expected 0", name, sb_q.size(), limit);
      sb_q.delete();
    end
  endtask

  // Monitor: record clk_out while busy and check each completed run on done.
  always @(negedge CLK) begin
    if (!RST_N) begin
      cap       = "";
      prev_busy = 1'b0;
    end else begin
      if (bus.busy && !prev_busy) cap = "";
      if (bus.busy) begin
        if (bus.clk_out) cap = {cap, "1"};
        else             cap = {cap, "0"};
      end
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 (periods=%0d) expected no done", bus.periods);
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "_periods"},   int'(bus.periods), mon_e.periods);
          check({mon_e.name, "_busy_low"},  int'(bus.busy),    0);
          check({mon_e.name, "_wave_len"},  cap.len(),         mon_e.wave.len());
          check({mon_e.name, "_wave_diff"}, first_diff(cap, mon_e.wave), -1);
        end
        cap = "";
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.high_cnt  = '0;
    bus.low_cnt   = '0;
    bus.burst_len = '0;
    RST_N         = 1'b0;
    tick(2);
    check("rst_clk_out", int'(bus.clk_out), 0);
    check("rst_busy",    int'(bus.busy),    0);
    check("rst_done",    int'(bus.done),    0);
    check("rst_periods", int'(bus.periods), 0);
    RST_N = 1'b1;
    tick(1);

    // Burst of 4 periods, 2 high + 3 low; done lands on cycle 21 after start.
    expect_run("t1_burst4", rep("11000", 4), 4);
    start_run(2, 3, 4);
    drain("t1", 100);
    tick(3);
    check("t1_periods_hold", int'(bus.periods), 4);
    check("t1_busy_idle",    int'(bus.busy),    0);
    check("t1_clk_idle",     int'(bus.clk_out), 0);

    // stop alone in IDLE, then start+stop together: both stops are dropped.
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    expect_run("t_startstop", rep("10", 2), 2);
    bus.high_cnt  = 16'd1;
    bus.low_cnt   = 16'd1;
    bus.burst_len = 8'd2;
    bus.start     = 1'b1;
    bus.stop      = 1'b1;
    tick(1);
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    drain("t_startstop", 50);

    // Continuous 0/0 (acts as 1/1); stop arrives in HIGH of the 5th period.
    expect_run("t2_stop", rep("10", 5), 5);
    start_run(0, 0, 0);
    tick(8);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    drain("t2", 50);

    // Continuous 4/4; widths change to 1/1 mid-HIGH and apply at the boundary.
    expect_run("t3_reconf", {"11110000", "10"}, 2);
    start_run(4, 4, 0);
    tick(2);
    bus.high_cnt = 16'd1;
    bus.low_cnt  = 16'd1;
    tick(6);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    drain("t3", 50);

    // A second start while busy (with different config) is ignored.
    expect_run("t4_restart", rep("111000", 2), 2);
    start_run(3, 3, 2);
    tick(3);
    bus.high_cnt  = 16'd1;
    bus.low_cnt   = 16'd1;
    bus.burst_len = 8'd7;
    bus.start     = 1'b1;
    tick(1);
    bus.start     = 1'b0;
    bus.high_cnt  = 16'd3;
    bus.low_cnt   = 16'd3;
    bus.burst_len = 8'd0;
    drain("t4", 50);
    tick(20);

    // Reset in the HIGH phase of period 2 aborts at once.
    start_run(2, 2, 0);
    tick(5);
    check("t5_busy_before",    int'(bus.busy),    1);
    check("t5_periods_before", int'(bus.periods), 1);
    RST_N = 1'b0;
    tick(1);
    check("t5_rst_clk_out", int'(bus.clk_out), 0);
    check("t5_rst_busy",    int'(bus.busy),    0);
    check("t5_rst_done",    int'(bus.done),    0);
    check("t5_rst_periods", int'(bus.periods), 0);
    RST_N = 1'b1;
    tick(1);
    expect_run("t5_after", rep("100", 3), 3);
    start_run(1, 2, 3);
    drain("t5", 50);

    // Burst equal to the counter maximum, then a continuous run past saturation.
    expect_run("t6_burst_max", rep("10", 255), 255);
    start_run(1, 1, 255);
    drain("t6a", 700);
    expect_run("t6_sat", rep("10", 301), 255);
    start_run(1, 1, 0);
    tick(600);
    check("t6_periods_sat_mid", int'(bus.periods), 255);
    check("t6_busy_mid",        int'(bus.busy),    1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    drain("t6b", 50);

    tick(5);
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
